// File: rtl/matrix_scan_if.sv
// Scan-side bundle between the LED matrix driver pins and the loopback decoder.
// The master drives the row/column pins; the slave returns rebuilt frames and status.
interface matrix_scan_if #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int ERR_W = 8
);
    logic [ROWS-1:0]            row_sink;
    logic [COLS-1:0]            red_driver;
    logic [COLS-1:0]            green_driver;
    logic [ROWS-1:0][COLS-1:0]  red_frame;
    logic [ROWS-1:0][COLS-1:0]  green_frame;
    logic                       frame_valid;
    logic                       frame_changed;
    logic                       locked;
    logic [ERR_W-1:0]           err_count;

    modport master (
        output row_sink, red_driver, green_driver,
        input  red_frame, green_frame, frame_valid, frame_changed, locked, err_count
    );

    modport slave (
        input  row_sink, red_driver, green_driver,
        output red_frame, green_frame, frame_valid, frame_changed, locked, err_count
    );
endinterface

// File: rtl/matrix_scan_decoder.sv
// Rebuilds red/green frames from the row-scanned matrix pins and counts scan-order errors.
// Define SCAN_SYNC_EN to pass the pins through a 2-flop synchroniser before classification.
module matrix_scan_decoder #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int ERR_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    matrix_scan_if.slave scan
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    typedef logic [ROWS-1:0][COLS-1:0] frame_t;
    typedef enum logic {HUNT, CAPTURE} state_t;

    function automatic logic [RW-1:0] next_row(input logic [RW-1:0] r);
        return (r == LAST_ROW) ? '0 : r + RW'(1);
    endfunction

    function automatic logic [RW-1:0] prev_row(input logic [RW-1:0] r);
        return (r == '0) ? LAST_ROW : r - RW'(1);
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + ERR_W'(1);
    endfunction

    logic [ROWS-1:0] row_s;
    logic [COLS-1:0] red_s;
    logic [COLS-1:0] green_s;

`ifdef SCAN_SYNC_EN
    logic [ROWS-1:0] row_m_q,   row_s_q;
    logic [COLS-1:0] red_m_q,   red_s_q;
    logic [COLS-1:0] green_m_q, green_s_q;

    // Idle pins (no row selected) is the safe reset value for the row synchroniser.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_m_q   <= '1;
            row_s_q   <= '1;
            red_m_q   <= '0;
            red_s_q   <= '0;
            green_m_q <= '0;
            green_s_q <= '0;
        end else begin
            row_m_q   <= scan.row_sink;
            row_s_q   <= row_m_q;
            red_m_q   <= scan.red_driver;
            red_s_q   <= red_m_q;
            green_m_q <= scan.green_driver;
            green_s_q <= green_m_q;
        end
    end

    assign row_s   = row_s_q;
    assign red_s   = red_s_q;
    assign green_s = green_s_q;
`else
    assign row_s   = scan.row_sink;
    assign red_s   = scan.red_driver;
    assign green_s = scan.green_driver;
`endif

    logic [ROWS-1:0] act_rows;
    logic            sel_blank;
    logic            sel_one;
    logic [RW-1:0]   sel_idx;

    always_comb begin
        act_rows  = ~row_s;
        sel_blank = (act_rows == '0);
        sel_one   = !sel_blank && ((act_rows & (act_rows - ROWS'(1))) == '0);
        sel_idx   = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (act_rows[i]) sel_idx = RW'(i);
        end
    end

    state_t           state_q, state_d;
    logic [RW-1:0]    exp_q, exp_d;
    logic [ERR_W-1:0] err_q, err_d;
    frame_t           sh_red_q, sh_red_d;
    frame_t           sh_green_q, sh_green_d;
    frame_t           red_q, red_d;
    frame_t           green_q, green_d;
    logic             fv_q, fv_d;
    logic             fc_q, fc_d;
    logic             wr_row;
    logic             publish;

    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        err_d      = err_q;
        sh_red_d   = sh_red_q;
        sh_green_d = sh_green_q;
        red_d      = red_q;
        green_d    = green_q;
        fv_d       = 1'b0;
        fc_d       = 1'b0;
        wr_row     = 1'b0;
        publish    = 1'b0;

        case (state_q)
            HUNT: begin
                if (sel_one && sel_idx == '0) begin
                    wr_row  = 1'b1;
                    exp_d   = next_row('0);
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (sel_blank) begin
                    wr_row = 1'b0;
                end else if (sel_one && sel_idx == exp_q) begin
                    wr_row  = 1'b1;
                    exp_d   = next_row(exp_q);
                    publish = (exp_q == LAST_ROW);
                end else if (sel_one && sel_idx == prev_row(exp_q)) begin
                    // Driver held the previous row for extra cycles: latest data wins.
                    wr_row = 1'b1;
                end else begin
                    err_d = sat_inc(err_q);
                    if (sel_one && sel_idx == '0) begin
                        wr_row = 1'b1;
                        exp_d  = next_row('0);
                    end else begin
                        state_d = HUNT;
                        exp_d   = '0;
                    end
                end
            end
            default: begin
                state_d = HUNT;
                exp_d   = '0;
            end
        endcase

        if (wr_row) begin
            sh_red_d[sel_idx]   = red_s;
            sh_green_d[sel_idx] = green_s;
        end

        // Publish includes the last row sampled this cycle, hence the _d buffers.
        if (publish) begin
            red_d   = sh_red_d;
            green_d = sh_green_d;
            fv_d    = 1'b1;
            fc_d    = (sh_red_d != red_q) || (sh_green_d != green_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= HUNT;
            exp_q      <= '0;
            err_q      <= '0;
            sh_red_q   <= '0;
            sh_green_q <= '0;
            red_q      <= '0;
            green_q    <= '0;
            fv_q       <= 1'b0;
            fc_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            err_q      <= err_d;
            sh_red_q   <= sh_red_d;
            sh_green_q <= sh_green_d;
            red_q      <= red_d;
            green_q    <= green_d;
            fv_q       <= fv_d;
            fc_q       <= fc_d;
        end
    end

    assign scan.red_frame     = red_q;
    assign scan.green_frame   = green_q;
    assign scan.frame_valid   = fv_q;
    assign scan.frame_changed = fc_q;
    assign scan.locked        = (state_q == CAPTURE);
    assign scan.err_count     = err_q;
endmodule

// File: tb/tb_matrix_scan_decoder.sv
// Self-checking bench for matrix_scan_decoder: vector table, directed corner cases,
// and randomized scans checked against a cycle-level reference model.
module tb_matrix_scan_decoder;
    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int ERR_W = 8;
`ifdef SCAN_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    typedef logic [ROWS-1:0][COLS-1:0] frame_t;

    typedef struct {
        logic [7:0] rs;
        logic [7:0] rd;
        logic [7:0] gd;
        logic       fv;
        logic       fc;
        logic       lk;
        logic [7:0] err;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    matrix_scan_if #(.ROWS(ROWS), .COLS(COLS), .ERR_W(ERR_W)) bus ();
    matrix_scan_decoder #(.ROWS(ROWS), .COLS(COLS), .ERR_W(ERR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .scan  (bus)
    );

    int checks  = 0;
    int errors  = 0;
    int fv_seen = 0;

    // Reference model state
    bit         m_lock;
    int         m_exp;
    int         m_err;
    frame_t     m_shr, m_shg, m_red, m_green;
    bit         m_fv, m_fc;
    logic [23:0] dq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [7:0] rowsel(input int i);
        logic [7:0] one;
        one = 8'b1;
        return ~(one << i);
    endfunction

    task automatic model_reset();
        m_lock = 0; m_exp = 0; m_err = 0;
        m_shr = '0; m_shg = '0; m_red = '0; m_green = '0;
        m_fv = 0; m_fc = 0;
        dq.delete();
        for (int i = 0; i < LAT; i++) dq.push_back({8'hFF, 8'h00, 8'h00});
    endtask

    task automatic model_write(input int idx, input logic [7:0] rd, input logic [7:0] gd);
        m_shr[idx] = rd;
        m_shg[idx] = gd;
    endtask

    task automatic model_edge(input logic [23:0] s);
        logic [7:0] rs, rd, gd;
        int nz, idx;
        rs = s[23:16]; rd = s[15:8]; gd = s[7:0];
        nz = 0; idx = -1;
        for (int i = 0; i < ROWS; i++) if (!rs[i]) begin nz++; idx = i; end
        m_fv = 0; m_fc = 0;
        if (!m_lock) begin
            if (nz == 1 && idx == 0) begin
                model_write(0, rd, gd); m_lock = 1; m_exp = 1;
            end
        end else if (nz == 0) begin
            m_fv = 0;
        end else if (nz == 1 && idx == m_exp) begin
            model_write(idx, rd, gd);
            if (m_exp == ROWS - 1) begin
                m_fc = (m_shr != m_red) || (m_shg != m_green);
                m_red = m_shr; m_green = m_shg; m_fv = 1;
            end
            m_exp = (m_exp + 1) % ROWS;
        end else if (nz == 1 && idx == (m_exp + ROWS - 1) % ROWS) begin
            model_write(idx, rd, gd);
        end else begin
            if (m_err < 255) m_err++;
            if (nz == 1 && idx == 0) begin
                model_write(0, rd, gd); m_exp = 1;
            end else begin
                m_lock = 0; m_exp = 0;
            end
        end
    endtask

    task automatic step(input logic [7:0] rs, input logic [7:0] rd, input logic [7:0] gd);
        @(negedge clk);
        bus.row_sink = rs; bus.red_driver = rd; bus.green_driver = gd;
        @(posedge clk);
        #1;
        dq.push_back({rs, rd, gd});
        model_edge(dq.pop_front());
        if (bus.frame_valid === 1'b1) fv_seen++;
        chk("model_valid",   64'(bus.frame_valid),   64'(m_fv));
        chk("model_changed", 64'(bus.frame_changed), 64'(m_fc));
        chk("model_locked",  64'(bus.locked),        64'(m_lock));
        chk("model_err",     64'(bus.err_count),     64'(m_err));
        chk("model_red",     bus.red_frame,          m_red);
        chk("model_green",   bus.green_frame,        m_green);
    endtask

    task automatic flush();
        for (int i = 0; i < LAT; i++) step(8'hFF, 8'h00, 8'h00);
    endtask

    task automatic clean_frame(input logic [7:0] rbase, input logic [7:0] gbase);
        for (int i = 0; i < ROWS; i++) step(rowsel(i), rbase ^ 8'(i), gbase + 8'(i));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_red"},     bus.red_frame,            64'd0);
        chk({tag, "_green"},   bus.green_frame,          64'd0);
        chk({tag, "_valid"},   64'(bus.frame_valid),     64'd0);
        chk({tag, "_changed"}, 64'(bus.frame_changed),   64'd0);
        chk({tag, "_locked"},  64'(bus.locked),          64'd0);
        chk({tag, "_err"},     64'(bus.err_count),       64'd0);
    endtask

    vec_t tbl[24];

    initial begin
        frame_t pr, pg;
        int e0;

        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < ROWS; i++) begin
                int k;
                k = f * 8 + i;
                tbl[k].rs  = rowsel(i);
                tbl[k].rd  = 8'h81;
                tbl[k].gd  = (f == 2 && i == 3) ? 8'hFF : 8'(i);
                tbl[k].fv  = (i == 7);
                tbl[k].fc  = (i == 7) && (f != 1);
                tbl[k].lk  = 1'b1;
                tbl[k].err = 8'h00;
            end
        end

        reset = 1'b1;
        bus.row_sink = 8'hFF; bus.red_driver = 8'h00; bus.green_driver = 8'h00;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Clean scan, identical repeat, then green row 3 changed
        for (int k = 0; k < 24 + LAT; k++) begin
            if (k < 24) step(tbl[k].rs, tbl[k].rd, tbl[k].gd);
            else        step(8'hFF, 8'h00, 8'h00);
            if (k >= LAT) begin
                chk($sformatf("tbl_valid[%0d]", k - LAT),   64'(bus.frame_valid),   64'(tbl[k-LAT].fv));
                chk($sformatf("tbl_changed[%0d]", k - LAT), 64'(bus.frame_changed), 64'(tbl[k-LAT].fc));
                chk($sformatf("tbl_locked[%0d]", k - LAT),  64'(bus.locked),        64'(tbl[k-LAT].lk));
                chk($sformatf("tbl_err[%0d]", k - LAT),     64'(bus.err_count),     64'(tbl[k-LAT].err));
            end
        end
        chk("tbl_green3", 64'(bus.green_frame[3]), 64'h FF);
        chk("tbl_green5", 64'(bus.green_frame[5]), 64'h05);
        chk("tbl_red0",   64'(bus.red_frame[0]),   64'h81);
        chk("tbl_red7",   64'(bus.red_frame[7]),   64'h81);

        // Out-of-order row aborts the partial frame
        pr = bus.red_frame; pg = bus.green_frame; e0 = int'(bus.err_count);
        fv_seen = 0;
        step(rowsel(0), 8'h11, 8'h22);
        step(rowsel(1), 8'h11, 8'h22);
        step(rowsel(2), 8'h11, 8'h22);
        step(rowsel(5), 8'h11, 8'h22);
        flush();
        chk("ooo_err",    64'(bus.err_count), 64'(e0 + 1));
        chk("ooo_locked", 64'(bus.locked),    64'd0);
        chk("ooo_red",    bus.red_frame,      pr);
        chk("ooo_green",  bus.green_frame,    pg);
        chk("ooo_nofv",   64'(fv_seen),       64'd0);
        clean_frame(8'h5A, 8'h30);
        flush();
        chk("ooo_recover_fv", 64'(fv_seen), 64'd1);

        // BAD row pattern mid-frame
        e0 = int'(bus.err_count);
        step(rowsel(0), 8'h01, 8'h02);
        step(rowsel(1), 8'h01, 8'h02);
        step(8'hF0,     8'h01, 8'h02);
        flush();
        chk("bad_err",    64'(bus.err_count), 64'(e0 + 1));
        chk("bad_locked", 64'(bus.locked),    64'd0);

        // BLANK cycles between rows 4 and 5
        e0 = int'(bus.err_count); fv_seen = 0;
        for (int i = 0; i < 5; i++) step(rowsel(i), 8'hC3, 8'(8'h40 + i));
        for (int i = 0; i < 3; i++) step(8'hFF, 8'h00, 8'h00);
        for (int i = 5; i < 8; i++) step(rowsel(i), 8'hC3, 8'(8'h40 + i));
        flush();
        chk("blank_err",   64'(bus.err_count),      64'(e0));
        chk("blank_fv",    64'(fv_seen),            64'd1);
        chk("blank_green", 64'(bus.green_frame[6]), 64'h46);

        // Row 2 held for four cycles
        e0 = int'(bus.err_count);
        step(rowsel(0), 8'h00, 8'h00);
        step(rowsel(1), 8'h00, 8'h00);
        step(rowsel(2), 8'h11, 8'h00);
        step(rowsel(2), 8'h22, 8'h00);
        step(rowsel(2), 8'h33, 8'h00);
        step(rowsel(2), 8'h3C, 8'h00);
        for (int i = 3; i < 8; i++) step(rowsel(i), 8'h00, 8'h00);
        flush();
        chk("held_err",  64'(bus.err_count),    64'(e0));
        chk("held_red2", 64'(bus.red_frame[2]), 64'h3C);

        // Async reset mid-frame, observed before any clock edge
        clean_frame(8'hA5, 8'h0F);
        for (int i = 0; i < 5; i++) step(rowsel(i), 8'h77, 8'h88);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        model_reset();
        @(negedge clk);
        bus.row_sink = 8'hFF; bus.red_driver = 8'h00; bus.green_driver = 8'h00;
        @(negedge clk);
        reset = 1'b0;

        // Saturating error counter
        for (int n = 0; n < 300; n++) begin
            step(rowsel(0), 8'h00, 8'h00);
            step(8'hF0,     8'h00, 8'h00);
        end
        flush();
        chk("sat_err", 64'(bus.err_count), 64'd255);

        // Randomized scans with blanks, held rows and junk
        begin
            int cur, prev, r;
            cur = 0; prev = 7;
            for (int n = 0; n < 2500; n++) begin
                r = $urandom_range(0, 99);
                if (r < 70) begin
                    step(rowsel(cur), 8'($urandom), 8'($urandom));
                    prev = cur; cur = (cur + 1) % ROWS;
                end else if (r < 80) begin
                    step(8'hFF, 8'($urandom), 8'($urandom));
                end else if (r < 88) begin
                    step(rowsel(prev), 8'($urandom), 8'($urandom));
                end else if (r < 94) begin
                    cur = $urandom_range(0, 7);
                    step(rowsel(cur), 8'($urandom), 8'($urandom));
                    prev = cur; cur = (cur + 1) % ROWS;
                end else begin
                    step(8'($urandom), 8'($urandom), 8'($urandom));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
